// File: rtl/matcher_pkg.sv
// Definitions shared between the word loader and the matcher it feeds:
// default word geometry, the padding byte and the loader's state encoding.
package matcher_pkg;

  localparam int DEFAULT_DATA_WIDTH  = 8;
  localparam int DEFAULT_WORD_LENGTH = 3;

  localparam logic [7:0] NULL_BYTE = 8'h00;

  typedef enum logic [1:0] {
    FILL,
    DRAIN,
    HOLD,
    RELEASE
  } loader_state_t;

endpackage

// File: rtl/word_loader.sv
// Packs a last-delimited byte stream into one fixed-length word per token (first byte in the MSBs).
// It then holds the word with cs high until the matcher reports done.
module word_loader
  import matcher_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int WORD_LENGTH = DEFAULT_WORD_LENGTH,
  parameter int CNT_WIDTH   = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              s_valid,
  input  logic [DATA_WIDTH-1:0]             s_data,
  input  logic                              s_last,
  output logic                              s_ready,
  output logic [WORD_LENGTH*DATA_WIDTH-1:0] word,
  output logic                              cs,
  input  logic                              match_done,
  output logic [CNT_WIDTH-1:0]              word_count,
  output logic                              trunc_err,
  input  logic                              err_clr
);

  localparam int IDX_W  = (WORD_LENGTH > 1) ? $clog2(WORD_LENGTH) : 1;
  localparam int WORD_W = WORD_LENGTH * DATA_WIDTH;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_LENGTH - 1);
  localparam logic [WORD_W-1:0] EMPTY_WORD = {WORD_LENGTH{DATA_WIDTH'(NULL_BYTE)}};

  loader_state_t    state, next_state;
  logic [IDX_W-1:0] idx;
  logic             ready_en;  // holds s_ready low for the first cycle out of reset
  logic             accept;

  assign accept = s_valid && s_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= next_state;
  end

  // NOTE: every output of this block gets a default before the case, so no path leaves one unassigned (no latch).
  always_comb begin
    next_state = state;
    s_ready    = 1'b0;
    case (state)
      FILL: begin
        s_ready = ready_en;
        if (s_valid && ready_en) begin
          if (s_last)                next_state = HOLD;
          else if (idx == LAST_IDX)  next_state = DRAIN;
        end
      end
      DRAIN: begin
        s_ready = ready_en;
        if (s_valid && ready_en && s_last) next_state = HOLD;
      end
      HOLD: begin
        if (match_done) next_state = RELEASE;
      end
      RELEASE: next_state = FILL;
      default: next_state = FILL;
    endcase
  end

  // NOTE: state and datapath registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en   <= 1'b0;
      idx        <= '0;
      word       <= EMPTY_WORD;
      cs         <= 1'b0;
      word_count <= '0;
      trunc_err  <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      cs       <= (next_state == HOLD);

      if (state == FILL && accept) begin
        for (int k = 0; k < WORD_LENGTH; k++) begin
          if (idx == IDX_W'(k)) word[(WORD_LENGTH-k)*DATA_WIDTH-1 -: DATA_WIDTH] <= s_data;
        end
        idx <= idx + 1'b1;
      end

      // Word is cleared on entry to RELEASE so the matcher never sees a stale token with cs low.
      if (state == HOLD && match_done) begin
        word       <= EMPTY_WORD;
        idx        <= '0;
        word_count <= word_count + 1'b1;
      end

      if (state == DRAIN && accept && s_last) trunc_err <= 1'b1;
      else if (err_clr)                       trunc_err <= 1'b0;
    end
  end

endmodule
